uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver; counterpart of the top-level tx_data transmit path. Samples serial rx line,
//   recovers 8N1 frames (8E1 with parity option), presents bytes on a valid/ready holding register.
//   Sits beside the TX path in FPGA_top; feeds command/byte stream into core logic.
// PARAMETERS
//   CLK_FREQ      100_000_000  system clock frequency, Hz
//   BAUD          115200       line rate, bit/s
//   CLKS_PER_BIT  CLK_FREQ/BAUD  clocks per bit (derived localparam, min 4)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  asynchronous, active-low reset (0 = reset)
//   rx_data    in   1  serial line, idle high, asynchronous to clk
//   data_o     out  8  received byte, LSB first on line
//   valid_o    out  1  data_o holds unread byte
//   ready_i    in   1  consumer accepts byte when valid_o & ready_i
//   frame_err  out  1  1-cycle pulse: stop bit sampled 0
//   overrun    out  1  sticky: new byte completed while valid_o still high; clear on accept
//   busy       out  1  FSM not in IDLE
// BEHAVIOUR
//   Reset: data_o=0, valid_o=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, sync flops=1.
//   Input sync: 2-flop synchronizer on rx_data; all decisions use synced value (2-clk latency).
//   Counters: clk_cnt counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit_idx 0..7.
//   FSM:
//     IDLE   : synced rx=0 -> START, clk_cnt=0.
//     START  : at clk_cnt=CLKS_PER_BIT/2-1 (mid start bit): rx=0 -> DATA, clk_cnt=0;
//              rx=1 -> glitch, back to IDLE, no outputs.
//     DATA   : at clk_cnt=CLKS_PER_BIT-1 sample rx into shift[bit_idx]; after bit 7 -> PARITY
//              (if enabled) else STOP.
//     PARITY : one bit time, sample parity bit -> STOP.
//     STOP   : at clk_cnt=CLKS_PER_BIT-1 sample stop bit:
//              1 -> commit byte (see below), -> IDLE.
//              0 -> frame_err pulse, byte discarded, -> WAIT_IDLE.
//     WAIT_IDLE: stay until synced rx=1 (break/stuck-low line), then IDLE.
//   Commit: data_o<=shift, valid_o<=1. If valid_o already 1 and not accepted same cycle:
//     overwrite data_o with new byte, overrun<=1.
//   Accept: valid_o & ready_i -> valid_o<=0, overrun<=0 next cycle. Commit and accept in
//     same cycle: old byte consumed, new byte loaded, valid_o stays 1, no overrun.
//   Latency: valid_o rises 1 clk after stop-bit mid sample (~9.5 bit times + 3 clk after
//     start edge; 10.5 with parity).
//   busy=1 in all states except IDLE. Reset asserted mid-frame: immediate return to reset
//     values; partial byte lost; next frame received normally after rst release.
//   frame_err and parity_err never assert together for one frame (framing takes priority).
// CONFIGURATION
//   UART_RX_PARITY_EN defined: frame is 8E1; PARITY state present; extra output
//     parity_err out 1 -- 1-cycle pulse when XOR(data,parity bit)!=0 at stop; byte still
//     committed (valid_o=1) so consumer may inspect.
//   Undefined: 8N1; no PARITY state; parity_err port absent.
// TESTING  (bench: CLK_FREQ=1_000_000, BAUD=100_000 -> CLKS_PER_BIT=10)
//   Send 0xA5 8N1, ready_i=1 -> valid_o 1-clk pulse, data_o=0xA5, frame_err=0, overrun=0.
//   Send 0x3C then 0xC3 with ready_i=0 -> after 2nd frame data_o=0xC3, valid_o=1,
//     overrun=1; raise ready_i -> valid_o=0, overrun=0 next clk.
//   Send 0x55 with stop bit forced 0, line low 30 clk -> frame_err pulse once, valid_o=0,
//     FSM holds WAIT_IDLE until line high, then 0x12 received correctly.
//   Low glitch of 3 clk on idle line -> returns to IDLE, no valid_o, no frame_err.
//   Assert rst (0) at bit 4 of frame 0xFF, release 5 clk later -> all outputs 0; next
//     frame 0x81 received as 0x81.
//   UART_RX_PARITY_EN: send 0x07 with parity 1 -> data_o=0x07, parity_err=0; parity 0 ->
//     parity_err pulse, valid_o=1, data_o=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, 8N1 by default (8E1 when UART_RX_PARITY_EN is defined).
//
// Oversamples the asynchronous serial line with the system clock, recovers
// one byte per frame and holds it in a valid/ready register for the core.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : frame is start + 8 data + even parity + stop; adds parity_err output
//   undefined : frame is start + 8 data + stop; parity_err port absent
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line rate in bit/s (CLK_FREQ/BAUD must be at least 4)
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   rx_data    serial line, idle high, asynchronous to clk
//   data_o     received byte (LSB first on the line)
//   valid_o    data_o holds an unread byte
//   ready_i    consumer takes the byte when valid_o & ready_i
//   frame_err  one-cycle pulse: stop bit sampled low, byte dropped
//   overrun    sticky: a byte was overwritten before being read; cleared on accept
//   busy       receiver not idle
//   parity_err one-cycle pulse with the commit of a byte whose parity is wrong
//              (only with UART_RX_PARITY_EN)
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q;
  logic          valid_q, ferr_q, ovr_q;
  logic          commit, ferr_d, accept;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q, par_bit_d;
  logic          perr_q;
`endif

  // Everything below decides on the synchronized line value only.
  wire rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    commit    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Re-check the line at the middle of the start bit to reject glitches;
        // from here on every sample lands mid-bit.
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Low stop bit: drop the byte and wait out a break/stuck-low line.
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = valid_q & ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= rx_data;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      if (commit) data_q <= shift_q;
      // A commit in the same cycle as an accept replaces the consumed byte
      // without flagging an overrun.
      valid_q   <= commit | (valid_q & ~accept);
      ovr_q     <= (ovr_q & ~accept) | (commit & valid_q & ~ready_i);
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      // Even parity: the data bits plus parity bit must XOR to zero.
      perr_q    <= commit & ((^shift_q) ^ par_bit_q);
`endif
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed and randomized frames into uart_rx, checked
// against a reference built from the frame format (CLKS_PER_BIT = 10).
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Event monitor: counts new bytes, valid-high cycles and error pulses.
  int         rx_cnt  = 0;
  int         vhi_cnt = 0;
  int         fe_cnt  = 0;
  int         pe_cnt  = 0;
  logic [7:0] rx_last = 8'h00;
  logic       valid_prev = 1'b0;

  always @(negedge clk) begin
    valid_prev <= valid_o;
    if (valid_o && !valid_prev) begin
      rx_cnt  <= rx_cnt + 1;
      rx_last <= data_o;
    end
    if (valid_o)   vhi_cnt <= vhi_cnt + 1;
    if (frame_err) fe_cnt  <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_data = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask
  task automatic send_good(input logic [7:0] b, input logic stop_bit);
    send_frame(b, stop_bit, ^b);   // even parity
  endtask
`else
  task automatic send_good(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask
`endif

  logic [7:0] exp_q[$];
  logic [7:0] b;
  int         c0, v0, f0, p0;

  initial begin
    rst = 1'b0; rx_data = 1'b1; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",    32'(data_o),    32'h00);
    check("reset_valid",   32'(valid_o),   32'h0);
    check("reset_ferr",    32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun),   32'h0);
    check("reset_busy",    32'(busy),      32'h0);
    rst = 1'b1;
    idle(5);

    // 0xA5 with ready high: one-cycle valid pulse
    c0 = rx_cnt; v0 = vhi_cnt; f0 = fe_cnt;
    send_good(8'hA5, 1'b1);
    idle(4);
    check("a5_count",   32'(rx_cnt - c0),  32'd1);
    check("a5_data",    32'(rx_last),      32'hA5);
    check("a5_pulse",   32'(vhi_cnt - v0), 32'd1);
    check("a5_ferr",    32'(fe_cnt - f0),  32'd0);
    check("a5_overrun", 32'(overrun),      32'h0);
    check("a5_busy",    32'(busy),         32'h0);

    // Overrun: two frames without reading
    ready_i = 1'b0;
    send_good(8'h3C, 1'b1);
    idle(3);
    check("ovr_first_data",  32'(data_o),  32'h3C);
    check("ovr_first_valid", 32'(valid_o), 32'h1);
    check("ovr_first_flag",  32'(overrun), 32'h0);
    send_good(8'hC3, 1'b1);
    idle(3);
    check("ovr_second_data",  32'(data_o),  32'hC3);
    check("ovr_second_valid", 32'(valid_o), 32'h1);
    check("ovr_second_flag",  32'(overrun), 32'h1);
    ready_i = 1'b1;
    @(negedge clk);
    check("ovr_accept_valid", 32'(valid_o), 32'h0);
    check("ovr_accept_flag",  32'(overrun), 32'h0);
    idle(3);

    // Framing error: stop bit low, line held low 30 clocks in total
    c0 = rx_cnt; f0 = fe_cnt; p0 = pe_cnt;
    send_good(8'h55, 1'b0);
    rx_data = 1'b0;
    repeat (20) @(negedge clk);
    check("ferr_wait_busy", 32'(busy),          32'h1);
    check("ferr_pulses",    32'(fe_cnt - f0),   32'd1);
    check("ferr_no_byte",   32'(rx_cnt - c0),   32'd0);
    check("ferr_valid",     32'(valid_o),       32'h0);
    check("ferr_no_perr",   32'(pe_cnt - p0),   32'd0);
    idle(5);
    check("ferr_released",  32'(busy),          32'h0);
    send_good(8'h12, 1'b1);
    idle(4);
    check("after_ferr_count", 32'(rx_cnt - c0), 32'd1);
    check("after_ferr_data",  32'(rx_last),     32'h12);

    // 3-clock low glitch on an idle line
    c0 = rx_cnt; f0 = fe_cnt;
    rx_data = 1'b0;
    repeat (3) @(negedge clk);
    idle(20);
    check("glitch_busy",  32'(busy),        32'h0);
    check("glitch_count", 32'(rx_cnt - c0), 32'd0);
    check("glitch_ferr",  32'(fe_cnt - f0), 32'd0);

    // Reset in the middle of bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (5) @(negedge clk);
    check("midframe_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_data",    32'(data_o),    32'h00);
    check("rst_mid_valid",   32'(valid_o),   32'h0);
    check("rst_mid_busy",    32'(busy),      32'h0);
    check("rst_mid_overrun", 32'(overrun),   32'h0);
    check("rst_mid_ferr",    32'(frame_err), 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    c0 = rx_cnt;
    idle(30);
    check("post_rst_idle",  32'(busy),        32'h0);
    check("post_rst_none",  32'(rx_cnt - c0), 32'd0);
    send_good(8'h81, 1'b1);
    idle(4);
    check("post_rst_count", 32'(rx_cnt - c0), 32'd1);
    check("post_rst_data",  32'(rx_last),     32'h81);

    // Random bytes checked through a scoreboard queue
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      c0 = rx_cnt;
      send_good(b, 1'b1);
      idle(3 + int'($urandom_range(0, 7)));
      check("rand_count", 32'(rx_cnt - c0), 32'd1);
      check("rand_data",  32'(rx_last),     32'(exp_q.pop_front()));
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data ^ parity must be 0
    p0 = pe_cnt; c0 = rx_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("par_ok_data", 32'(rx_last),      32'h07);
    check("par_ok_perr", 32'(pe_cnt - p0),  32'(((^8'h07) ^ 1'b1) ? 1 : 0));
    ready_i = 1'b0;
    p0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(3);
    check("par_bad_perr",  32'(pe_cnt - p0), 32'(((^8'h07) ^ 1'b0) ? 1 : 0));
    check("par_bad_valid", 32'(valid_o),     32'h1);
    check("par_bad_data",  32'(data_o),      32'h07);
    ready_i = 1'b1;
    idle(3);
    for (int k = 0; k < 4; k++) begin
      logic pb;
      b  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      p0 = pe_cnt; c0 = rx_cnt;
      send_frame(b, 1'b1, pb);
      idle(4);
      check("rand_par_data", 32'(rx_last),     32'(b));
      check("rand_par_perr", 32'(pe_cnt - p0), 32'(((^b) != pb) ? 1 : 0));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
